// File: rtl/pipe_unit_rr_arbiter_pkg.sv
// Shared helpers for the pipe-unit round-robin arbiter: grant search and ID decode.
// Functions work on a fixed maximum width; callers size-cast the result to N_REQ bits.
package pipe_arb_pkg;

    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = 5;

    // One-hot grant: first set bit of req searching ptr, ptr+1, ... wrapping at n_req.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n_req) begin
                idx = ptr + i;
                if (idx >= n_req) idx = idx - n_req;
                if (!found && req[idx[MAX_ID_W-1:0]]) begin
                    grant[idx[MAX_ID_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot_decode(input logic [MAX_ID_W-1:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/pipe_unit_rr_arbiter_if.sv
// Bundle of requester-side and unit-side signals around the shared-unit arbiter.
interface pipe_unit_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_rdy;
    logic                   unit_in_vld;
    logic [WIDTH-1:0]       unit_in_data;
    logic                   unit_out_vld;
    logic [WIDTH-1:0]       unit_out_data;
    logic [N_REQ-1:0]       rsp_vld;
    logic [WIDTH-1:0]       rsp_data;
    logic                   tag_err;

    modport slave (
        input  req_vld, req_data, unit_out_vld, unit_out_data,
        output req_rdy, unit_in_vld, unit_in_data, rsp_vld, rsp_data, tag_err
    );

    modport master (
        output req_vld, req_data, unit_out_vld, unit_out_data,
        input  req_rdy, unit_in_vld, unit_in_data, rsp_vld, rsp_data, tag_err
    );
endinterface

// File: rtl/pipe_unit_rr_arbiter_tag_shift_register.sv
// Valid-qualified shift register carrying requester IDs in step with the shared unit.
// Only the valid chain is reset; the ID chain is plain data.
module tag_shift_register #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);
    logic [DEPTH-1:0] r_vld_p;
    logic [WIDTH-1:0] r_data_p [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_data_p[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_data_p[i] <= r_data_p[i-1];
    end

    assign o_vld  = r_vld_p[DEPTH-1];
    assign o_data = r_data_p[DEPTH-1];
endmodule

// File: rtl/pipe_unit_rr_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined unit between N_REQ requesters,
// with results steered back to their issuer by a tag pipe matched to the unit latency.
module pipe_unit_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input logic                   clk,
    input logic                   rst,
    pipe_unit_rr_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]  r_ptr;
    logic             r_unit_in_vld;
    logic [WIDTH-1:0] r_unit_in_data;
    logic [ID_W-1:0]  r_issue_id;
    logic             r_tag_err;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_xfer;
    logic [N_REQ-1:0] w_rsp_onehot;
    tag_t             w_tag_in;
    tag_t             w_tag_out;

    // Grant is suppressed while in reset so nothing is accepted into a flushing pipe.
    assign w_grant = rst ? '0
                         : N_REQ'(rr_pick(MAX_REQ'(bus.req_vld), 32'(r_ptr), N_REQ));
    assign w_xfer  = |w_grant;

    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = ID_W'(i);
                w_grant_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_rdy = w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_unit_in_vld <= 1'b0;
        end else begin
            r_unit_in_vld <= w_xfer;
            if (w_xfer)
                r_ptr <= (w_grant_idx == ID_W'(N_REQ-1)) ? '0 : w_grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_unit_in_data <= w_grant_data;
            r_issue_id     <= w_grant_idx;
        end
    end

    assign bus.unit_in_vld  = r_unit_in_vld;
    assign bus.unit_in_data = r_unit_in_data;

    assign w_tag_in.vld = r_unit_in_vld;
    assign w_tag_in.id  = r_issue_id;

    tag_shift_register #(
        .WIDTH (ID_W),
        .DEPTH (LATENCY)
    ) u_tag_sr (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_tag_in.vld),
        .i_data (w_tag_in.id),
        .o_vld  (w_tag_out.vld),
        .o_data (w_tag_out.id)
    );

    // Response steering: only a result matched by a live tag reaches a requester.
    assign w_rsp_onehot = N_REQ'(onehot_decode(MAX_ID_W'(w_tag_out.id)));
    assign bus.rsp_vld  = (!rst && bus.unit_out_vld && w_tag_out.vld) ? w_rsp_onehot : '0;
    assign bus.rsp_data = bus.unit_out_data;

    always_ff @(posedge clk) begin
        if (rst)
            r_tag_err <= 1'b0;
        else if (bus.unit_out_vld != w_tag_out.vld)
            r_tag_err <= 1'b1;
    end

    assign bus.tag_err = r_tag_err;
endmodule

// File: tb/tb_pipe_unit_rr_arbiter.sv
// Directed bench: a 4-requester/4-latency arbiter and a 1-requester/1-latency corner,
// each driving a behavioural unit whose result is operand + 1.
module tb_pipe_unit_rr_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pipe_unit_rr_arbiter_if #(.N_REQ(4), .WIDTH(32)) bus4 ();
    pipe_unit_rr_arbiter_if #(.N_REQ(1), .WIDTH(32)) bus1 ();

    pipe_unit_rr_arbiter #(.N_REQ(4), .WIDTH(32), .LATENCY(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    pipe_unit_rr_arbiter #(.N_REQ(1), .WIDTH(32), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit models: LATENCY-deep pipes, reset together with the arbiter.
    logic [3:0]  u4_vld;
    logic [31:0] u4_data [4];
    logic        fault4;
    logic        u1_vld;
    logic [31:0] u1_data;

    always @(posedge clk) begin
        if (rst) u4_vld <= 4'b0;
        else     u4_vld <= {u4_vld[2:0], bus4.unit_in_vld};
        u4_data[0] <= bus4.unit_in_data;
        for (int i = 1; i < 4; i++) u4_data[i] <= u4_data[i-1];
        if (rst) u1_vld <= 1'b0;
        else     u1_vld <= bus1.unit_in_vld;
        u1_data <= bus1.unit_in_data;
    end

    assign bus4.unit_out_vld  = u4_vld[3] | fault4;
    assign bus4.unit_out_data = u4_data[3] + 32'd1;
    assign bus1.unit_out_vld  = u1_vld;
    assign bus1.unit_out_data = u1_data + 32'd1;

    task automatic do_reset();
        rst          = 1'b1;
        bus4.req_vld = 4'b0;
        bus1.req_vld = 1'b0;
        fault4       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus4.req_vld = 4'b1111;
        bus1.req_vld = 1'b1;
        #1;
        n_cmp++;
        if (bus4.req_rdy !== 4'b0000) begin
            n_err++; $display("FAIL reset_rdy got %b expected 0000", bus4.req_rdy);
        end
        n_cmp++;
        if (bus1.req_rdy !== 1'b0) begin
            n_err++; $display("FAIL reset_rdy1 got %b expected 0", bus1.req_rdy);
        end
        n_cmp++;
        if (bus4.unit_in_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_unit_in_vld got %b expected 0", bus4.unit_in_vld);
        end
        n_cmp++;
        if (bus4.rsp_vld !== 4'b0000) begin
            n_err++; $display("FAIL reset_rsp_vld got %b expected 0000", bus4.rsp_vld);
        end
        n_cmp++;
        if (bus4.tag_err !== 1'b0) begin
            n_err++; $display("FAIL reset_tag_err got %b expected 0", bus4.tag_err);
        end
        bus4.req_vld = 4'b0;
        bus1.req_vld = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus4.req_data = {32'd0, 32'd0, 32'd0, 32'd16};
        for (int c = 0; c < 7; c++) begin
            bus4.req_vld = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (c == 0) begin
                n_cmp++;
                if (bus4.req_rdy !== 4'b0001) begin
                    n_err++; $display("FAIL single_rdy got %b expected 0001", bus4.req_rdy);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (bus4.unit_in_vld !== 1'b1 || bus4.unit_in_data !== 32'd16) begin
                    n_err++; $display("FAIL single_issue got vld=%b data=%0d expected vld=1 data=16",
                                      bus4.unit_in_vld, bus4.unit_in_data);
                end
            end
            n_cmp++;
            if (bus4.rsp_vld !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL single_rsp_vld cycle %0d got %b", c, bus4.rsp_vld);
            end
            if (c == 5) begin
                n_cmp++;
                if (bus4.rsp_data !== 32'd17) begin
                    n_err++; $display("FAIL single_rsp_data got %0d expected 17", bus4.rsp_data);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_rdy;
        logic [3:0] exp_rsp;
        do_reset();
        bus4.req_data = {32'd103, 32'd102, 32'd101, 32'd100};
        for (int c = 0; c < 14; c++) begin
            bus4.req_vld = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            exp_rsp = (c >= 5 && c < 13) ? 4'(1 << ((c - 5) % 4)) : 4'b0000;
            n_cmp++;
            if (bus4.req_rdy !== exp_rdy) begin
                n_err++; $display("FAIL sat_rdy cycle %0d got %b expected %b", c, bus4.req_rdy, exp_rdy);
            end
            n_cmp++;
            if (bus4.rsp_vld !== exp_rsp) begin
                n_err++; $display("FAIL sat_rsp_vld cycle %0d got %b expected %b", c, bus4.rsp_vld, exp_rsp);
            end
            if (exp_rsp != 4'b0000) begin
                n_cmp++;
                if (bus4.rsp_data !== 32'(101 + (c - 5) % 4)) begin
                    n_err++; $display("FAIL sat_rsp_data cycle %0d got %0d expected %0d",
                                      c, bus4.rsp_data, 101 + (c - 5) % 4);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus4.tag_err !== 1'b0) begin
            n_err++; $display("FAIL sat_tag_err got %b expected 0", bus4.tag_err);
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_data;
        do_reset();
        bus4.req_data = {32'd303, 32'd302, 32'd301, 32'd300};
        for (int c = 0; c < 10; c++) begin
            case (c)
                0:       bus4.req_vld = 4'b0100;
                1, 2:    bus4.req_vld = 4'b0011;
                default: bus4.req_vld = 4'b0000;
            endcase
            case (c)
                0:       exp_rdy = 4'b0100;
                1:       exp_rdy = 4'b0001;
                2:       exp_rdy = 4'b0010;
                default: exp_rdy = 4'b0000;
            endcase
            case (c)
                5:       begin exp_rsp = 4'b0100; exp_data = 32'd303; end
                6:       begin exp_rsp = 4'b0001; exp_data = 32'd301; end
                7:       begin exp_rsp = 4'b0010; exp_data = 32'd302; end
                default: begin exp_rsp = 4'b0000; exp_data = 32'd0;   end
            endcase
            #1;
            n_cmp++;
            if (bus4.req_rdy !== exp_rdy) begin
                n_err++; $display("FAIL wrap_rdy cycle %0d got %b expected %b", c, bus4.req_rdy, exp_rdy);
            end
            n_cmp++;
            if (bus4.rsp_vld !== exp_rsp) begin
                n_err++; $display("FAIL wrap_rsp_vld cycle %0d got %b expected %b", c, bus4.rsp_vld, exp_rsp);
            end
            if (exp_rsp != 4'b0000) begin
                n_cmp++;
                if (bus4.rsp_data !== exp_data) begin
                    n_err++; $display("FAIL wrap_rsp_data cycle %0d got %0d expected %0d",
                                      c, bus4.rsp_data, exp_data);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus4.req_data = {32'd203, 32'd202, 32'd201, 32'd200};
        for (int c = 0; c < 3; c++) begin
            bus4.req_vld = 4'b1111;
            #1;
            n_cmp++;
            if (bus4.req_rdy !== 4'(1 << c)) begin
                n_err++; $display("FAIL mid_rdy cycle %0d got %b expected %b", c, bus4.req_rdy, 4'(1 << c));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus4.req_rdy !== 4'b0000) begin
            n_err++; $display("FAIL mid_rdy_in_rst got %b expected 0000", bus4.req_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        bus4.req_vld = 4'b1000;
        #1;
        n_cmp++;
        if (bus4.req_rdy !== 4'b1000) begin
            n_err++; $display("FAIL mid_rdy_after got %b expected 1000", bus4.req_rdy);
        end
        @(negedge clk);
        bus4.req_vld = 4'b0000;
        for (int c = 1; c < 9; c++) begin
            #1;
            n_cmp++;
            if (bus4.rsp_vld !== ((c == 5) ? 4'b1000 : 4'b0000)) begin
                n_err++; $display("FAIL mid_rsp_vld cycle %0d got %b", c, bus4.rsp_vld);
            end
            if (c == 5) begin
                n_cmp++;
                if (bus4.rsp_data !== 32'd204) begin
                    n_err++; $display("FAIL mid_rsp_data got %0d expected 204", bus4.rsp_data);
                end
            end
            n_cmp++;
            if (bus4.tag_err !== 1'b0) begin
                n_err++; $display("FAIL mid_tag_err cycle %0d got %b expected 0", c, bus4.tag_err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fault();
        do_reset();
        fault4 = 1'b1;
        #1;
        n_cmp++;
        if (bus4.rsp_vld !== 4'b0000) begin
            n_err++; $display("FAIL fault_rsp_vld got %b expected 0000", bus4.rsp_vld);
        end
        @(negedge clk);
        fault4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (bus4.tag_err !== 1'b1) begin
                n_err++; $display("FAIL fault_tag_err_sticky cycle %0d got %b expected 1", c, bus4.tag_err);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus4.tag_err !== 1'b0) begin
            n_err++; $display("FAIL fault_tag_err_cleared got %b expected 0", bus4.tag_err);
        end
        @(negedge clk);
    endtask

    task automatic test_corner_single_req();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus1.req_vld  = 1'b1;
            bus1.req_data = 32'(50 + c);
            #1;
            n_cmp++;
            if (bus1.req_rdy !== 1'b1) begin
                n_err++; $display("FAIL corner_rdy cycle %0d got %b expected 1", c, bus1.req_rdy);
            end
            n_cmp++;
            if (bus1.rsp_vld !== ((c >= 2) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL corner_rsp_vld cycle %0d got %b", c, bus1.rsp_vld);
            end
            if (c >= 2) begin
                n_cmp++;
                if (bus1.rsp_data !== 32'(49 + c)) begin
                    n_err++; $display("FAIL corner_rsp_data cycle %0d got %0d expected %0d",
                                      c, bus1.rsp_data, 49 + c);
                end
            end
            @(negedge clk);
        end
        bus1.req_vld = 1'b0;
        #1;
        n_cmp++;
        if (bus1.tag_err !== 1'b0) begin
            n_err++; $display("FAIL corner_tag_err got %b expected 0", bus1.tag_err);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        fault4        = 1'b0;
        bus4.req_vld  = 4'b0;
        bus4.req_data = '0;
        bus1.req_vld  = 1'b0;
        bus1.req_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_saturation();
        test_wrap();
        test_reset_midflight();
        test_fault();
        test_corner_single_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
